// File: rtl/cost_rom_arbiter.sv
// cost_rom_arbiter
//   Shares one combinational worker/job cost table between two requesters.
//   Arbitration is round-robin. A requester can lock the table for a burst of
//   at most MAX_BURST cycles. One lookup is issued per cycle, and its response
//   returns one cycle after the table address is registered.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   req0/1, w0/1, j0/1      lookup request with worker and job index
//   lock0/1                 keep ownership after this beat
//   gnt0/1                  combinational grant; beat accepted on req&gnt
//   rom_w, rom_j            registered table address
//   rom_cost                table data for the current rom_w/rom_j
//   rsp_valid0/1            one-cycle response pulse tagged by requester
//   rsp_cost                registered returned cost
//   force_rel               one-cycle pulse when a lock hits MAX_BURST
module cost_rom_arbiter #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned CW        = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [2:0]    w0,
  input  logic [2:0]    j0,
  input  logic          lock0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [2:0]    w1,
  input  logic [2:0]    j1,
  input  logic          lock1,
  output logic          gnt1,
  output logic [2:0]    rom_w,
  output logic [2:0]    rom_j,
  input  logic [CW-1:0] rom_cost,
  output logic          rsp_valid0,
  output logic          rsp_valid1,
  output logic [CW-1:0] rsp_cost,
  output logic          force_rel
);

  localparam int unsigned BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           ptr;
  logic           ptr_nxt;
  logic [BCW-1:0] burst_cnt;
  logic [BCW-1:0] burst_cnt_nxt;
  logic           force_nxt;
  logic           burst_last;
  logic           acc0;
  logic           acc1;

  // In-flight lookup: valid flag and owning requester
  logic           pend;
  logic           tag;

  assign acc0       = req0 & gnt0;
  assign acc1       = req1 & gnt1;
  assign burst_last = (burst_cnt == BCW'(MAX_BURST - 1));

  // State register, priority pointer and burst counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Next-state logic
  // A beat accepted in the limit cycle still completes. The release is only
  // flagged as forced when the beat did not release the lock itself.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    burst_cnt_nxt = burst_cnt;
    force_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        burst_cnt_nxt = '0;
        if (acc0) begin
          if (lock0) state_nxt = OWN0;
          else       ptr_nxt   = 1'b1;
        end else if (acc1) begin
          if (lock1) state_nxt = OWN1;
          else       ptr_nxt   = 1'b0;
        end
      end
      OWN0: begin
        if (acc0 && !lock0) begin
          state_nxt     = IDLE;
          ptr_nxt       = 1'b1;
          burst_cnt_nxt = '0;
        end else if (burst_last) begin
          state_nxt     = IDLE;
          ptr_nxt       = 1'b1;
          burst_cnt_nxt = '0;
          force_nxt     = 1'b1;
        end else begin
          burst_cnt_nxt = burst_cnt + BCW'(1);
        end
      end
      OWN1: begin
        if (acc1 && !lock1) begin
          state_nxt     = IDLE;
          ptr_nxt       = 1'b0;
          burst_cnt_nxt = '0;
        end else if (burst_last) begin
          state_nxt     = IDLE;
          ptr_nxt       = 1'b0;
          burst_cnt_nxt = '0;
          force_nxt     = 1'b1;
        end else begin
          burst_cnt_nxt = burst_cnt + BCW'(1);
        end
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  // Grant logic: round-robin while idle, exclusive while owned
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state)
      IDLE: begin
        gnt0 = req0 & (~ptr | ~req1);
        gnt1 = req1 & ( ptr | ~req0);
      end
      OWN0:    gnt0 = 1'b1;
      OWN1:    gnt1 = 1'b1;
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
  end

  // Address issue: register the accepted beat's index and tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_w <= '0;
      rom_j <= '0;
      pend  <= 1'b0;
      tag   <= 1'b0;
    end else begin
      if (acc0) begin
        rom_w <= w0;
        rom_j <= j0;
        tag   <= 1'b0;
        pend  <= 1'b1;
      end else if (acc1) begin
        rom_w <= w1;
        rom_j <= j1;
        tag   <= 1'b1;
        pend  <= 1'b1;
      end else begin
        pend  <= 1'b0;
      end
    end
  end

  // Response capture: table data is valid one cycle after the address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_cost   <= '0;
      force_rel  <= 1'b0;
    end else begin
      rsp_valid0 <= pend & ~tag;
      rsp_valid1 <= pend &  tag;
      if (pend) rsp_cost <= rom_cost;
      force_rel  <= force_nxt;
    end
  end

endmodule
